word_nibble_tx: RTL

- Transmit-side serializer. Accepts one WORD_W-bit word (int-sized by default) per handshake and emits it as a stream of NIB_W-bit nibbles over a valid/ready link.
- It is the counterpart of the team's nibble-to-int capture logic: that logic builds an int from 4-bit values, and this block breaks an int back down into 4-bit values.
- It sits between a word-wide producer and a 4-bit-wide link or consumer.

---
 rtl/word_nibble_pkg.sv | 19 +
 rtl/word_nibble_tx.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/word_nibble_pkg.sv
// Shared types and constants for the word-to-nibble transmit serializer.
// nib_xor() folds a default-width word into one nibble (checksum reference).
package word_nibble_pkg;

    typedef enum logic [1:0] {IDLE, SEND, CSUM} tx_state_t;

    localparam int WORD_W_DEF = 32;
    localparam int NIB_W_DEF  = 4;

    function automatic logic [NIB_W_DEF-1:0] nib_xor(input logic [WORD_W_DEF-1:0] word);
        logic [NIB_W_DEF-1:0] acc;
        acc = '0;
        for (int i = 0; i < WORD_W_DEF / NIB_W_DEF; i++) begin
            acc = acc ^ word[i*NIB_W_DEF +: NIB_W_DEF];
        end
        return acc;
    endfunction

endpackage

// File: rtl/word_nibble_tx.sv
// Serializes one WORD_W word per handshake into NIB_W beats on a valid/ready link.
// Define WORD_NIBBLE_TX_CSUM_EN to append an XOR-of-nibbles checksum beat.
module word_nibble_tx
    import word_nibble_pkg::*;
#(
    parameter int WORD_W    = WORD_W_DEF,
    parameter int NIB_W     = NIB_W_DEF,
    parameter int LSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NIB_W-1:0]  out_nib,
    output logic              out_last,
    output logic              busy
);

    localparam int NUM_NIB = WORD_W / NIB_W;
    localparam int CNT_W   = $clog2(NUM_NIB + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_NIB - 1);

    tx_state_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WORD_W-1:0]  shreg_q, shreg_d;
    logic               in_ready_q, in_ready_d;
    logic [NIB_W-1:0]   cur_nib;
`ifdef WORD_NIBBLE_TX_CSUM_EN
    logic [NIB_W-1:0]   csum_q, csum_d;
`endif

    always_comb begin
        if (LSB_FIRST != 0) begin
            cur_nib = shreg_q[NIB_W-1:0];
        end else begin
            cur_nib = shreg_q[WORD_W-1 -: NIB_W];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        in_ready_d = in_ready_q;
`ifdef WORD_NIBBLE_TX_CSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    shreg_d    = in_data;
                    cnt_d      = '0;
                    state_d    = SEND;
                    in_ready_d = 1'b0;
`ifdef WORD_NIBBLE_TX_CSUM_EN
                    csum_d     = '0;
`endif
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (LSB_FIRST != 0) begin
                        shreg_d = shreg_q >> NIB_W;
                    end else begin
                        shreg_d = shreg_q << NIB_W;
                    end
                    cnt_d = cnt_q + CNT_W'(1);
`ifdef WORD_NIBBLE_TX_CSUM_EN
                    csum_d = csum_q ^ cur_nib;
                    if (cnt_q == LAST_CNT) begin
                        state_d = CSUM;
                    end
`else
                    if (cnt_q == LAST_CNT) begin
                        state_d    = IDLE;
                        in_ready_d = 1'b1;
                    end
`endif
                end
            end
`ifdef WORD_NIBBLE_TX_CSUM_EN
            CSUM: begin
                if (out_ready) begin
                    state_d    = IDLE;
                    in_ready_d = 1'b1;
                end
            end
`endif
            default: begin
                state_d    = IDLE;
                in_ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            in_ready_q <= in_ready_d;
        end
    end

`ifdef WORD_NIBBLE_TX_CSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    // Outputs decode straight from registered state, so out_ready never reaches in_ready.
    always_comb begin
        out_valid = 1'b0;
        out_nib   = '0;
        out_last  = 1'b0;
        case (state_q)
            SEND: begin
                out_valid = 1'b1;
                out_nib   = cur_nib;
`ifndef WORD_NIBBLE_TX_CSUM_EN
                out_last  = (cnt_q == LAST_CNT);
`endif
            end
`ifdef WORD_NIBBLE_TX_CSUM_EN
            CSUM: begin
                out_valid = 1'b1;
                out_nib   = csum_q;
                out_last  = 1'b1;
            end
`endif
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

    assign in_ready = in_ready_q;
    assign busy     = (state_q != IDLE);

endmodule
